// File: rtl/wls_pkg.sv
// wls_pkg: shared types and constants for the weight load scheduler.
package wls_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_SWAP, STREAM, FINISH} drain_state_t;
    localparam int BEAT_W        = 64;
    localparam int ROW_W         = 128;
    localparam int BEATS_PER_ROW = ROW_W / BEAT_W;
endpackage

// File: rtl/wls_fill_tracker.sv
// wls_fill_tracker: counts accepted beats into rows and flags a full fill bank.
module wls_fill_tracker
    import wls_pkg::*;
#(
    parameter int ROWS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic beat,
    input  logic swap,
    output logic fill_full
);
    localparam int BW = $clog2(BEATS_PER_ROW);
    localparam int RW = $clog2(ROWS);
    logic [BW-1:0] beat_cnt;
    logic [RW-1:0] row_cnt;
    logic beat_last, row_last;
    assign beat_last = beat_cnt == BW'(BEATS_PER_ROW - 1);
    assign row_last  = row_cnt == RW'(ROWS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            row_cnt   <= '0;
            fill_full <= 1'b0;
        end else if (clear) begin
            beat_cnt  <= '0;
            row_cnt   <= '0;
            fill_full <= 1'b0;
        end else begin
            if (swap)
                fill_full <= 1'b0;
            if (beat) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + BW'(1);
                if (beat_last) begin
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                    if (row_last)
                        fill_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/weight_load_scheduler.sv
// weight_load_scheduler: ping-pong fill/drain scheduling of weight tiles into the PE array.
// Optional drain stall counter enabled by defining WLS_STALL_CNT_EN.
module weight_load_scheduler
    import wls_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int TILE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [TILE_CNT_W-1:0] i_num_tiles,
    input  logic                  i_beat,
    input  logic                  i_array_ready,
    output logic                  o_fill_allow,
    output logic                  o_bank_swap,
    output logic                  o_weight_load_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [31:0]           o_stall_cycles
);
    localparam int RW = $clog2(ROWS);
    drain_state_t state, state_nx;
    logic [TILE_CNT_W-1:0] num_tiles, tiles_filled, tiles_drained;
    logic [RW-1:0] row_cnt;
    logic drain_empty, fill_full, swap_q;
    logic start_ok, swap_set, row_last;
    assign start_ok         = i_start && state == IDLE;
    assign swap_set         = fill_full && drain_empty && state == WAIT_SWAP;
    assign o_busy           = state != IDLE;
    assign o_done           = state == FINISH;
    assign o_bank_swap      = swap_q;
    assign o_weight_load_en = state == STREAM && i_array_ready;
    assign row_last         = o_weight_load_en && row_cnt == RW'(ROWS - 1);
    assign o_fill_allow     = o_busy && !fill_full && tiles_filled < num_tiles;
    wls_fill_tracker #(.ROWS(ROWS)) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .beat      (i_beat && o_fill_allow),
        .swap      (swap_set),
        .fill_full (fill_full)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (start_ok) state_nx = i_num_tiles == '0 ? FINISH : WAIT_SWAP;
            WAIT_SWAP: if (swap_q) state_nx = STREAM;
            STREAM:    if (row_last) state_nx = tiles_drained == num_tiles - TILE_CNT_W'(1) ? FINISH : WAIT_SWAP;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            swap_q        <= 1'b0;
            num_tiles     <= '0;
            tiles_filled  <= '0;
            tiles_drained <= '0;
            drain_empty   <= 1'b1;
            row_cnt       <= '0;
        end else begin
            state  <= state_nx;
            swap_q <= swap_set;
            if (start_ok) begin
                num_tiles     <= i_num_tiles;
                tiles_filled  <= '0;
                tiles_drained <= '0;
                drain_empty   <= 1'b1;
                row_cnt       <= '0;
            end else begin
                // swap and drain completion live in different states, never the same edge
                if (swap_set) begin
                    drain_empty  <= 1'b0;
                    tiles_filled <= tiles_filled + TILE_CNT_W'(1);
                end
                if (o_weight_load_en)
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                if (row_last) begin
                    drain_empty   <= 1'b1;
                    tiles_drained <= tiles_drained + TILE_CNT_W'(1);
                end
            end
        end
    end
`ifdef WLS_STALL_CNT_EN
    logic [31:0] stall_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (start_ok)
            stall_cnt <= '0;
        else if (state == STREAM && !i_array_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
    assign o_stall_cycles = stall_cnt;
`else
    assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_weight_load_scheduler.sv
// tb_weight_load_scheduler: random and directed stimulus checked against a beat/row-count model.
module tb_weight_load_scheduler;
    localparam int R = 4;
`ifdef WLS_STALL_CNT_EN
    localparam int STALL_EXP = 3;
`else
    localparam int STALL_EXP = 0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, i_start = 1'b0, i_beat = 1'b0, i_array_ready = 1'b0;
    logic [15:0] i_num_tiles = '0;
    logic o_fill_allow, o_bank_swap, o_weight_load_en, o_busy, o_done;
    logic [31:0] o_stall_cycles;
    int checks = 0, errors = 0;
    int n_swap, n_load, n_done, n_fill;
    int m_n, m_beats, m_swapped, m_drained, m_rows_left, m_stall;
    bit m_active, m_done, m_swap;

    weight_load_scheduler #(.ROWS(R), .TILE_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_tiles(i_num_tiles),
        .i_beat(i_beat), .i_array_ready(i_array_ready), .o_fill_allow(o_fill_allow),
        .o_bank_swap(o_bank_swap), .o_weight_load_en(o_weight_load_en), .o_busy(o_busy),
        .o_done(o_done), .o_stall_cycles(o_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_n = 0; m_beats = 0; m_swapped = 0; m_drained = 0; m_rows_left = 0; m_stall = 0;
        m_active = 0; m_done = 0; m_swap = 0;
    endfunction

    // drain bank holds rows and the swap pulse has passed
    function automatic bit m_stream();
        return m_active && m_rows_left > 0 && !m_swap;
    endfunction

    function automatic bit m_fill();
        return m_active && m_beats < 2 * R && m_swapped < m_n;
    endfunction

    function automatic logic [4:0] m_outs(input bit r);
        return {m_fill(), m_swap, m_stream() && r, m_active || m_done, m_done};
    endfunction

    function automatic int m_stall_exp();
`ifdef WLS_STALL_CNT_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    function automatic void model_step(input bit s, input int num, input bit b, input bit r);
        bit fill, strm, new_swap;
        fill = m_fill();
        strm = m_stream();
        if (s && !(m_active || m_done)) begin
            model_reset();
            m_n = num;
            if (num == 0) m_done = 1; else m_active = 1;
            return;
        end
        m_done = 0;
        if (!m_active) return;
        new_swap = m_beats == 2 * R && m_rows_left == 0;
        if (b && fill) m_beats++;
        if (strm && !r) m_stall++;
        if (strm && r) begin
            m_rows_left--;
            if (m_rows_left == 0) begin
                m_drained++;
                if (m_drained == m_n) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
        end
        if (new_swap) begin
            m_beats = 0;
            m_rows_left = R;
            m_swapped++;
        end
        m_swap = new_swap;
    endfunction

    task automatic cycle(input bit s, input int num, input bit b, input bit r);
        i_start = s; i_num_tiles = 16'(num); i_beat = b; i_array_ready = r;
        #1;
        chk("outs", {27'd0, o_fill_allow, o_bank_swap, o_weight_load_en, o_busy, o_done}, {27'd0, m_outs(r)});
        chk("stall", o_stall_cycles, m_stall_exp());
        n_swap += int'(o_bank_swap); n_load += int'(o_weight_load_en);
        n_done += int'(o_done); n_fill += int'(o_fill_allow);
        @(posedge clk);
        model_step(s, num, b, r);
        @(negedge clk);
    endtask

    // mode_b: 0 beat every cycle, 1 random beats plus stray starts; mode_r: 0 ready, 1 toggle, 2 random
    task automatic run(input int mode_b, input int mode_r, input int maxc);
        bit tog = 1, st, b, r, s;
        for (int k = 0; k < maxc && (m_active || m_done); k++) begin
            st = m_stream();
            b = mode_b == 0 ? 1'b1 : ($urandom % 4 != 0);
            s = mode_b == 1 && ($urandom % 16 == 0);
            r = mode_r == 0 ? 1'b1 : mode_r == 1 ? tog : ($urandom % 3 != 0);
            cycle(s, int'($urandom_range(0, 5)), b, r);
            if (st) tog = !tog;
        end
        chk("timeout", 32'(m_active || m_done), 0);
    endtask

    task automatic clr();
        n_swap = 0; n_load = 0; n_done = 0; n_fill = 0;
    endtask

    initial begin
        model_reset();
        clr();
        repeat (2) @(negedge clk);
        chk("reset_outs", {27'd0, o_fill_allow, o_bank_swap, o_weight_load_en, o_busy, o_done}, 0);
        chk("reset_stall", o_stall_cycles, 0);
        rst_n = 1'b1;
        cycle(0, 0, 1, 1);

        cycle(1, 1, 0, 1);
        run(0, 0, 100);
        chk("t1_swaps", n_swap, 1); chk("t1_loads", n_load, 4); chk("t1_done", n_done, 1);

        clr();
        cycle(1, 3, 0, 1);
        repeat (3) cycle(1, 7, 1, 1);
        run(0, 0, 200);
        chk("t3_swaps", n_swap, 3); chk("t3_loads", n_load, 12); chk("t3_done", n_done, 1);

        clr();
        cycle(1, 1, 0, 1);
        run(0, 1, 100);
        chk("toggle_loads", n_load, 4); chk("toggle_stall", o_stall_cycles, STALL_EXP);

        clr();
        cycle(1, 0, 1, 1);
        run(0, 0, 10);
        chk("zero_done", n_done, 1); chk("zero_swaps", n_swap, 0);
        chk("zero_loads", n_load, 0); chk("zero_fill", n_fill, 0);

        clr();
        cycle(1, 3, 0, 1);
        for (int k = 0; k < 200 && !(m_swapped == 2 && m_stream()); k++) cycle(0, 0, 1, 1);
        chk("t2_stream_reached", 32'(m_swapped == 2 && m_stream()), 1);
        cycle(0, 0, 1, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {27'd0, o_fill_allow, o_bank_swap, o_weight_load_en, o_busy, o_done}, 0);
        chk("midrst_stall", o_stall_cycles, 0);
        model_reset();
        clr();
        @(negedge clk);
        repeat (2) cycle(0, 0, 1, 1);
        chk("midrst_no_done", n_done, 0);
        rst_n = 1'b1;
        cycle(1, 1, 0, 1);
        run(0, 0, 100);
        chk("post_rst_done", n_done, 1); chk("post_rst_loads", n_load, 4);

        for (int j = 0; j < 25; j++) begin
            clr();
            repeat ($urandom_range(0, 3)) cycle(0, 0, $urandom % 2, $urandom % 2);
            cycle(1, int'($urandom_range(0, 4)), $urandom % 2, 1);
            run(1, 2, 1000);
            chk("rnd_done", n_done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
